rlbp_pixel_seq: RTL and testbench



---
 rtl/rlbp_pkg.sv | 22 ++
 rtl/rlbp_phase_timer.sv | 35 +++
 rtl/rlbp_pixel_seq.sv | 169 ++++++++++++++++
 tb/tb_rlbp_pixel_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rlbp_pkg.sv
// Shared types and defaults for the pixel readout sequencer.
package rlbp_pkg;

  localparam int unsigned N_PD_DEF        = 12;
  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned MIN_DUR         = 1;

  typedef enum logic [3:0] {
    StIdle,
    StRst,
    StG1,
    StInt,
    StG2,
    StSh,
    StG3,
    StCmp,
    StLat,
    StDone
  } state_e;

endpackage

// File: rtl/rlbp_phase_timer.sv
// Shared phase down-counter: load a duration (0 clamps to 1), expire marks the last cycle.
module rlbp_phase_timer
  import rlbp_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (value_i == '0) ? CNT_W'(MIN_DUR) : value_i;
    end else if (cnt_q > CNT_W'(MIN_DUR)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CNT_W'(MIN_DUR));

endmodule

// File: rtl/rlbp_pixel_seq.sv
// Per-photodiode readout sequencer: drives analog switch phases, samples the comparator
// and assembles the local-binary-pattern code.
module rlbp_pixel_seq
  import rlbp_pkg::*;
#(
  parameter int unsigned N_PD        = N_PD_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] t_rst_i,
  input  logic [CNT_W-1:0] t_int_i,
  input  logic [CNT_W-1:0] t_sh_i,
  input  logic [CNT_W-1:0] t_cmp_i,
  input  logic             cmp_i,
  output logic             sh_rst_o,
  output logic             sw1_o,
  output logic             sw2_o,
  output logic             sh_o,
  output logic             sh_cmp_o,
  output logic [N_PD-1:0]  pd_a_o,
  output logic [N_PD-1:0]  pd_b_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [N_PD-1:0]  code_o
);

  localparam int unsigned KW = (N_PD > 1) ? $clog2(N_PD) : 1;

  state_e                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [CNT_W-1:0]       tr_q, tr_d, ti_q, ti_d, ts_q, ts_d, tc_q, tc_d;
  logic [N_PD-1:0]        shadow_q, shadow_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   tmr_load, tmr_expire;
  logic [CNT_W-1:0]       tmr_val;
  logic [N_PD-1:0]        sel_d;

  rlbp_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i    (wb_clk_i),
    .rst_ni   (rst_n),
    .load_i   (tmr_load),
    .value_i  (tmr_val),
    .expire_o (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    tr_d     = tr_q;
    ti_d     = ti_q;
    ts_d     = ts_q;
    tc_d     = tc_q;
    shadow_d = shadow_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          state_d  = StRst;
          k_d      = '0;
          tr_d     = t_rst_i;
          ti_d     = t_int_i;
          ts_d     = t_sh_i;
          tc_d     = t_cmp_i;
          tmr_load = 1'b1;
          tmr_val  = t_rst_i;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        if (abort_i) begin
          state_d = StIdle;
        end else if (tmr_expire) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(MIN_DUR);
          case (state_q)
            StRst: state_d = StG1;
            StG1: begin
              state_d = StInt;
              tmr_val = ti_q;
            end
            StInt: state_d = StG2;
            StG2: begin
              state_d = StSh;
              tmr_val = ts_q;
            end
            StSh: state_d = StG3;
            StG3: begin
              state_d = StCmp;
              tmr_val = tc_q;
            end
            StCmp: begin
              state_d = StLat;
              tmr_val = CNT_W'(SYNC_STAGES);
            end
            StLat: begin
              shadow_d[k_q] = sync_q[SYNC_STAGES-1];
              if (k_q == KW'(N_PD - 1)) begin
                state_d = StDone;
              end else begin
                k_d     = k_q + KW'(1);
                state_d = StRst;
                tmr_val = tr_q;
              end
            end
            default: state_d = StIdle;
          endcase
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so every control comes straight off a flop.
  assign sel_d = N_PD'(1) << k_d;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      k_q      <= '0;
      tr_q     <= '0;
      ti_q     <= '0;
      ts_q     <= '0;
      tc_q     <= '0;
      shadow_q <= '0;
      sync_q   <= '0;
      sh_rst_o <= 1'b0;
      sw1_o    <= 1'b0;
      sw2_o    <= 1'b0;
      sh_o     <= 1'b0;
      sh_cmp_o <= 1'b0;
      pd_a_o   <= '0;
      pd_b_o   <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      code_o   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      tr_q     <= tr_d;
      ti_q     <= ti_d;
      ts_q     <= ts_d;
      tc_q     <= tc_d;
      shadow_q <= shadow_d;
      sync_q[0] <= cmp_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sh_rst_o <= (state_d == StRst);
      sw1_o    <= (state_d == StInt);
      sw2_o    <= (state_d == StCmp);
      sh_o     <= (state_d == StSh);
      sh_cmp_o <= (state_d == StCmp);
      pd_a_o   <= (state_d == StInt || state_d == StSh) ? sel_d : '0;
      pd_b_o   <= (state_d == StCmp) ? sel_d : '0;
      busy_o   <= (state_d != StIdle) && (state_d != StDone);
      done_o   <= (state_d == StDone);
      if (state_d == StDone) begin
        code_o <= shadow_d;
      end
    end
  end

endmodule

// File: tb/tb_rlbp_pixel_seq.sv
// Scoreboard bench for the pixel readout sequencer.
module tb_rlbp_pixel_seq;

  logic        wb_clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0, abort_i = 1'b0, cmp_i = 1'b0;
  logic [7:0]  t_rst_i = 8'd1, t_int_i = 8'd1, t_sh_i = 8'd1, t_cmp_i = 8'd1;
  logic        sh_rst_o, sw1_o, sw2_o, sh_o, sh_cmp_o, busy_o, done_o;
  logic [11:0] pd_a_o, pd_b_o, code_o;

  int          total = 0, bad = 0, viol = 0;
  logic [11:0] pattern = 12'h000;
  logic [11:0] sb[$];
  bit          width_en = 1'b1;
  int          exp_w[4];
  int          run_len[4];
  logic [28:0] prev_vec = '0;

  rlbp_pixel_seq dut (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .abort_i  (abort_i),
    .t_rst_i  (t_rst_i),
    .t_int_i  (t_int_i),
    .t_sh_i   (t_sh_i),
    .t_cmp_i  (t_cmp_i),
    .cmp_i    (cmp_i),
    .sh_rst_o (sh_rst_o),
    .sw1_o    (sw1_o),
    .sw2_o    (sw2_o),
    .sh_o     (sh_o),
    .sh_cmp_o (sh_cmp_o),
    .pd_a_o   (pd_a_o),
    .pd_b_o   (pd_b_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .code_o   (code_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [11:0] v);
    for (int i = 0; i < 12; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int clamp(input logic [7:0] v);
    return (v == 8'd0) ? 1 : int'(v);
  endfunction

  // Comparator model: noise during reset, then the wanted bit for the photodiode in use.
  always @(negedge wb_clk_i) begin
    if (sh_rst_o) cmp_i = 1'($urandom_range(0, 1));
    else if (pd_a_o != '0) cmp_i = pattern[idx_of(pd_a_o)];
  end

  // Protocol monitor: exclusivity, one-hot selects, gap between phases, phase widths.
  always @(posedge wb_clk_i) begin
    logic [3:0]  grp;
    logic [28:0] cur;
    #1;
    grp = {sh_rst_o, sw1_o, sh_o, sw2_o | sh_cmp_o};
    cur = {sh_rst_o, sw1_o, sw2_o, sh_o, sh_cmp_o, pd_a_o, pd_b_o};
    if (!$onehot0(grp) || (sw2_o != sh_cmp_o)) viol++;
    if (!$onehot0(pd_a_o) || !$onehot0(pd_b_o) || (pd_a_o != '0 && pd_b_o != '0)) viol++;
    if (prev_vec != '0 && cur != '0 && cur != prev_vec) viol++;
    prev_vec = cur;
    for (int g = 0; g < 4; g++) begin
      if (grp[3-g]) run_len[g]++;
      else if (run_len[g] > 0) begin
        if (width_en && run_len[g] != exp_w[g]) viol++;
        run_len[g] = 0;
      end
    end
  end

  task automatic run_seq(input logic [7:0] tr, ti, ts, tc, input logic [11:0] pat,
                         input bit poke);
    int period, n, busy_cnt, done_cnt, done_at;
    t_rst_i = tr; t_int_i = ti; t_sh_i = ts; t_cmp_i = tc;
    pattern = pat;
    exp_w[0] = clamp(tr); exp_w[1] = clamp(ti); exp_w[2] = clamp(ts); exp_w[3] = clamp(tc);
    period = exp_w[0] + exp_w[1] + exp_w[2] + exp_w[3] + 5;
    viol = 0;
    sb.push_back(pat);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    @(negedge wb_clk_i) start_i = 1'b1;
    @(posedge wb_clk_i); #1;
    start_i = 1'b0;
    for (n = 1; n <= 12 * period + 12; n++) begin
      if (poke && n == 30) begin
        start_i = 1'b1;
        t_int_i = 8'd9;
      end else if (poke && n == 31) begin
        start_i = 1'b0;
      end
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
        check_eq("busy_at_done", 32'(busy_o), 32'd0);
        if (sb.size() == 0) check_eq("sb_empty", 32'd1, 32'd0);
        else check_eq("code", 32'(code_o), 32'(sb.pop_front()));
      end
      @(posedge wb_clk_i); #1;
    end
    check_eq("done_latency", 32'(done_at), 32'(1 + 12 * period));
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
    check_eq("busy_cycles", 32'(busy_cnt), 32'(12 * period));
    check_eq("protocol", 32'(viol), 32'd0);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n, dn;
    #23 rst_n = 1'b1;
    @(posedge wb_clk_i); #1;
    check_eq("rst_code", 32'(code_o), 32'd0);
    check_eq("rst_ctl", 32'({sh_rst_o, sw1_o, sw2_o, sh_o, sh_cmp_o, busy_o, done_o}), 32'd0);
    check_eq("rst_pd", 32'({pd_a_o, pd_b_o}), 32'd0);

    run_seq(8'd1, 8'd1, 8'd1, 8'd1, 12'hFFF, 1'b0);
    run_seq(8'd3, 8'd5, 8'd2, 8'd4, 12'h555, 1'b0);
    run_seq(8'd1, 8'd1, 8'd1, 8'd1, 12'hABC, 1'b0);

    // Abort during INT of k=5.
    width_en = 1'b0;
    pattern = 12'h0F0;
    @(negedge wb_clk_i) start_i = 1'b1;
    @(negedge wb_clk_i) start_i = 1'b0;
    n = 0;
    while (!(sw1_o && pd_a_o[5]) && n < 300) begin
      @(negedge wb_clk_i);
      n++;
    end
    check_eq("abort_reach_int5", 32'(n < 300), 32'd1);
    abort_i = 1'b1;
    @(posedge wb_clk_i); #1;
    abort_i = 1'b0;
    check_eq("abort_ctl", 32'({sh_rst_o, sw1_o, sw2_o, sh_o, sh_cmp_o, busy_o, done_o}), 32'd0);
    check_eq("abort_pd", 32'({pd_a_o, pd_b_o}), 32'd0);
    dn = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge wb_clk_i); #1;
      if (done_o || busy_o) dn++;
    end
    check_eq("abort_quiet", 32'(dn), 32'd0);
    check_eq("abort_code", 32'(code_o), 32'hABC);

    // Abort wins over start in IDLE.
    @(negedge wb_clk_i) begin start_i = 1'b1; abort_i = 1'b1; end
    @(negedge wb_clk_i) begin start_i = 1'b0; abort_i = 1'b0; end
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge wb_clk_i); #1;
      if (busy_o) dn++;
    end
    check_eq("abort_priority", 32'(dn), 32'd0);
    width_en = 1'b1;

    run_seq(8'd2, 8'd1, 8'd3, 8'd1, 12'h3C5, 1'b0);
    run_seq(8'd1, 8'd1, 8'd1, 8'd1, 12'h9A6, 1'b1);
    run_seq(8'd0, 8'd0, 8'd0, 8'd0, 12'h18E, 1'b0);

    // Asynchronous reset during CMP.
    width_en = 1'b0;
    @(negedge wb_clk_i) start_i = 1'b1;
    @(negedge wb_clk_i) start_i = 1'b0;
    n = 0;
    while (!sw2_o && n < 300) begin
      @(negedge wb_clk_i);
      n++;
    end
    check_eq("rst_reach_cmp", 32'(n < 300), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_code", 32'(code_o), 32'd0);
    check_eq("arst_ctl", 32'({sh_rst_o, sw1_o, sw2_o, sh_o, sh_cmp_o, busy_o, done_o}), 32'd0);
    check_eq("arst_pd", 32'({pd_a_o, pd_b_o}), 32'd0);
    @(negedge wb_clk_i) rst_n = 1'b1;
    @(posedge wb_clk_i); #1;
    check_eq("arst_idle", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
